// File: rtl/wvfm_gen.sv
// wvfm_gen: periodic test-waveform source (sine / square / sawtooth / zero)
// driven from an 8-point phase index, with a per-sample hold counter,
// index stride, amplitude right-shift and a registered signed output.
// Optional build macro WVFM_DC_OFFSET_EN adds a dc_offset port and a
// saturating offset adder on the sample path.
//
// state  | meaning
// S_IDLE | output forced to 0, index and hold counter cleared
// S_RUN  | emitting samples, each held for hold_period+1 cycles
module wvfm_gen #(
  parameter int DATA_W = 16,
  parameter int HOLD_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [HOLD_W-1:0]        hold_period,
  input  logic [2:0]               phase_step,
  input  logic [4:0]               amp_shift,
  input  logic [1:0]               mode,
`ifdef WVFM_DC_OFFSET_EN
  input  logic signed [DATA_W-1:0] dc_offset,
`endif
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_wrap
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Fit a 16-bit table entry to DATA_W: keep the top bits when narrower,
  // zero-fill on the right when wider.
  function automatic logic [DATA_W-1:0] scale16(input logic [15:0] v);
    logic [39:0] t;
    t = {v, 24'h0} >> (40 - DATA_W);
    return DATA_W'(t);
  endfunction

  localparam logic [DATA_W-1:0] SIN_1  = scale16(16'h5A7E);
  localparam logic [DATA_W-1:0] SIN_2  = scale16(16'h7FFF);
  localparam logic [DATA_W-1:0] SIN_5  = scale16(16'hA582);
  localparam logic [DATA_W-1:0] SIN_6  = scale16(16'h8000);
  localparam logic [4:0]        SH_LIM = 5'(DATA_W);
  localparam logic [4:0]        SH_MAX = 5'(DATA_W - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load;
  logic [2:0]          r_idx;
  logic [HOLD_W-1:0]   r_cnt;
  logic [HOLD_W-1:0]   r_hold;
  logic [3:0]          w_sum;
  logic [2:0]          w_idx_nxt;
  logic                w_wrap_nxt;
  logic signed [DATA_W-1:0] w_raw;
  logic signed [DATA_W-1:0] w_shifted;
  logic signed [DATA_W-1:0] w_out;
  logic [4:0]          w_shamt;

  // The sample being loaded: index 0 on IDLE exit, otherwise the stepped index.
  assign w_sum      = {1'b0, r_idx} + {1'b0, phase_step};
  assign w_idx_nxt  = (r_state == S_IDLE) ? 3'd0 : w_sum[2:0];
  assign w_wrap_nxt = (r_state == S_RUN) && w_sum[3];
  assign w_shamt    = (amp_shift >= SH_LIM) ? SH_MAX : amp_shift;
  assign w_shifted  = w_raw >>> w_shamt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and sample-boundary detection.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable)              w_state_nxt = S_IDLE;
        else if (r_cnt == r_hold) w_load      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Raw waveform value for the index being loaded.
  always_comb begin
    w_raw = '0;
    case (mode)
      2'b00: begin
        case (w_idx_nxt)
          3'd1, 3'd3: w_raw = SIN_1;
          3'd2:       w_raw = SIN_2;
          3'd5, 3'd7: w_raw = SIN_5;
          3'd6:       w_raw = SIN_6;
          default:    w_raw = '0;
        endcase
      end
      2'b01:   w_raw = w_idx_nxt[2] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
      2'b10:   w_raw = {~w_idx_nxt[2], w_idx_nxt[1:0], {(DATA_W-3){1'b0}}};
      default: w_raw = '0;
    endcase
  end

`ifdef WVFM_DC_OFFSET_EN
  logic signed [DATA_W:0] w_dc_sum;
  assign w_dc_sum = {w_shifted[DATA_W-1], w_shifted} + {dc_offset[DATA_W-1], dc_offset};

  // Clamp the offset sum back into DATA_W signed range.
  always_comb begin
    w_out = w_dc_sum[DATA_W-1:0];
    if (w_dc_sum[DATA_W] != w_dc_sum[DATA_W-1])
      w_out = w_dc_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign w_out = w_shifted;
`endif

  // Index, hold counter and registered outputs; hold_period is captured only
  // at sample boundaries so mid-sample changes wait for the next sample.
  always_ff @(posedge clk) begin
    if (reset || (w_state_nxt == S_IDLE)) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else if (w_load) begin
      r_idx   <= w_idx_nxt;
      r_cnt   <= '0;
      r_hold  <= hold_period;
      o_data  <= w_out;
      o_valid <= 1'b1;
      o_wrap  <= w_wrap_nxt;
    end else begin
      r_cnt   <= r_cnt + HOLD_W'(1);
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wvfm_gen.sv
// Bench for wvfm_gen: directed waveform tables with literal expectations,
// then randomized controls checked every cycle against a behavioural model.
module tb_wvfm_gen;
  localparam int DW = 16;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [HW-1:0] hold_period;
  logic [2:0]    phase_step;
  logic [4:0]    amp_shift;
  logic [1:0]    mode;
`ifdef WVFM_DC_OFFSET_EN
  logic [DW-1:0] dc_offset;
`endif
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_wrap;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  wvfm_gen #(.DATA_W(DW), .HOLD_W(HW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hold_period(hold_period),
    .phase_step(phase_step), .amp_shift(amp_shift), .mode(mode),
`ifdef WVFM_DC_OFFSET_EN
    .dc_offset(dc_offset),
`endif
    .o_data(o_data), .o_valid(o_valid), .o_wrap(o_wrap)
  );

  always #5 clk = ~clk;

  // Waveform value from the arithmetic definition of each mode.
  function automatic longint wave(int idx, int md, int sh, longint dc);
    longint sine16[8] = '{0, 23166, 32767, 23166, 0, -23166, -32768, -23166};
    longint half = longint'(1) << (DW - 1);
    longint v;
    longint lo;
    longint hi;
    case (md)
      0: v = (DW >= 16) ? sine16[idx] * (longint'(1) << (DW - 16)) : (sine16[idx] >>> (16 - DW));
      1: v = (idx < 4) ? half - 1 : -half;
      2: v = -half + longint'(idx) * (longint'(1) << (DW - 3));
      default: v = 0;
    endcase
    v = v >>> ((sh >= DW) ? DW - 1 : sh);
    v = v + dc;
    lo = -half;
    hi = half - 1;
    if (v < lo) v = lo;
    if (v > hi) v = hi;
    return v;
  endfunction

  // Behavioural model: a running flag, current index and cycles left in sample.
  bit            m_run = 1'b0;
  int            m_idx = 0;
  int            m_left = 0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_valid = 1'b0;
  logic          exp_wrap = 1'b0;

  // Model steps once per rising edge from the inputs held across that edge.
  always @(posedge clk) begin
    automatic longint dc = 0;
    automatic int s;
`ifdef WVFM_DC_OFFSET_EN
    dc = longint'($signed(dc_offset));
`endif
    if (reset || !enable) begin
      m_run <= 1'b0; m_idx <= 0; m_left <= 0;
      exp_data <= '0; exp_valid <= 1'b0; exp_wrap <= 1'b0;
    end else if (!m_run) begin
      m_run <= 1'b1; m_idx <= 0; m_left <= int'(hold_period);
      exp_data <= DW'(wave(0, int'(mode), int'(amp_shift), dc));
      exp_valid <= 1'b1; exp_wrap <= 1'b0;
    end else if (m_left == 0) begin
      s = m_idx + int'(phase_step);
      m_idx <= s % 8; m_left <= int'(hold_period);
      exp_data <= DW'(wave(s % 8, int'(mode), int'(amp_shift), dc));
      exp_valid <= 1'b1; exp_wrap <= (s > 7);
    end else begin
      m_left <= m_left - 1;
      exp_valid <= 1'b0; exp_wrap <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (o_data !== exp_data || o_valid !== exp_valid || o_wrap !== exp_wrap) begin
        n_err++;
        $display("FAIL model t=%0t: data=%h valid=%b wrap=%b expected data=%h valid=%b wrap=%b",
                 $time, o_data, o_valid, o_wrap, exp_data, exp_valid, exp_wrap);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chkd(string nm, logic [DW-1:0] ed, logic ev, logic ew);
    n_cmp++;
    if (o_data !== ed || o_valid !== ev || o_wrap !== ew) begin
      n_err++;
      $display("FAIL %s: data=%h valid=%b wrap=%b expected data=%h valid=%b wrap=%b",
               nm, o_data, o_valid, o_wrap, ed, ev, ew);
    end
  endtask

  // Drop enable for one cycle, load new controls and re-enable.
  task automatic restart(int hp, int st, int sh, int md);
    enable = 1'b0;
    nxt();
    chkd("idle", 16'h0000, 1'b0, 1'b0);
    hold_period = HW'(hp);
    phase_step  = 3'(st);
    amp_shift   = 5'(sh);
    mode        = 2'(md);
    enable      = 1'b1;
  endtask

  logic [15:0] sine_lit[8];
  logic [15:0] v16;

  initial begin
    sine_lit = '{16'h0000, 16'h5A7E, 16'h7FFF, 16'h5A7E, 16'h0000, 16'hA582, 16'h8000, 16'hA582};
    reset = 1'b1; enable = 1'b0; hold_period = '0; phase_step = '0; amp_shift = '0; mode = '0;
`ifdef WVFM_DC_OFFSET_EN
    dc_offset = '0;
`endif
    nxt();
    nxt();
    chk_en = 1'b1;
    chkd("reset", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    hold_period = 8'd4; phase_step = 3'd1; amp_shift = 5'd0; mode = 2'd0; enable = 1'b1;

    // Sine, hold 4, step 1: each sample 5 cycles; wrap on the 9th sample.
    for (int s = 0; s < 9; s++)
      for (int c = 0; c < 5; c++) begin
        nxt();
        chkd($sformatf("sine s%0d c%0d", s, c), sine_lit[s % 8], c == 0, (s == 8) && (c == 0));
      end

    // hold 0, step 2: new sample every cycle.
    restart(0, 2, 0, 0);
    for (int k = 0; k < 8; k++) begin
      nxt();
      chkd($sformatf("step2 k%0d", k), sine_lit[(2 * k) % 8], 1'b1, (k % 4 == 0) && (k > 0));
    end

    // Square and sawtooth at half amplitude, hold 1.
    restart(1, 1, 1, 1);
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 2; c++) begin
        nxt();
        chkd($sformatf("square s%0d c%0d", s, c), (s < 4) ? 16'h3FFF : 16'hC000, c == 0, 1'b0);
      end
    restart(1, 1, 1, 2);
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 2; c++) begin
        nxt();
        v16 = 16'hC000 + 16'(s) * 16'h1000;
        chkd($sformatf("saw s%0d c%0d", s, c), v16, c == 0, 1'b0);
      end

    // Mid-sample control change with hold 7.
    restart(7, 1, 0, 0);
    for (int c = 0; c < 8; c++) begin
      nxt();
      chkd($sformatf("midchg c%0d", c), 16'h0000, c == 0, 1'b0);
      if (c == 2) begin mode = 2'd1; phase_step = 3'd3; end
    end
    nxt();
    chkd("midchg new", 16'h7FFF, 1'b1, 1'b0);

    // Saturated shift: square gives 0 / -1.
    restart(0, 4, 20, 1);
    for (int k = 0; k < 4; k++) begin
      nxt();
      chkd($sformatf("satshift k%0d", k), (k % 2) ? 16'hFFFF : 16'h0000, 1'b1, (k % 2 == 0) && (k > 0));
    end

    // Reset during a 7FFF sample, then recovery at idx 0.
    restart(4, 1, 0, 0);
    for (int k = 0; k < 11; k++) nxt();
    chkd("pre-reset", 16'h7FFF, 1'b1, 1'b0);
    reset = 1'b1;
    nxt();
    chkd("reset mid", 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    nxt();
    chkd("reset recover", 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) nxt();
    chkd("reset next", 16'h5A7E, 1'b1, 1'b0);

    // Randomized controls; the model is checked on every cycle.
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 3) == 0) begin
        hold_period = HW'($urandom_range(0, 6));
        phase_step  = 3'($urandom_range(0, 7));
        amp_shift   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        mode        = 2'($urandom_range(0, 3));
`ifdef WVFM_DC_OFFSET_EN
        dc_offset   = DW'($urandom);
`endif
      end
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
